fifo_read_arbiter: RTL and testbench

//  Shares one tracking-FIFO read port (fifo_read/fifo_data, 1-cycle read latency) among NUM_REQ

---
 rtl/fifo_read_arbiter.sv | 171 +++++++++++++++++
 tb/tb_fifo_read_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter
//   Shares one tracking-FIFO read port among NUM_REQ sample consumers. Grants
//   are round-robin and cover whole bursts. A requester is granted only when
//   the FIFO already holds its full burst. Returned bytes are steered to the
//   winner with a one-hot strobe and a byte index.
//
// Ports
//   clk            single clock for the FIFO read side and all logic
//   reset          asynchronous, active-high
//   req            level request per consumer, held until its done pulse
//   req_len        burst byte count per consumer, packed as [3i+2:3i]
//   grant          one-hot, high from the first read issue until done
//   done           one-cycle pulse after the last byte of a burst is delivered
//   rd_data        FIFO read data passthrough, qualified by rd_valid
//   rd_valid       one-hot strobe: rd_data is a byte for that consumer
//   rd_index       byte index within the burst, meaningful with rd_valid
//   fifo_read      FIFO read enable
//   fifo_data      FIFO read data, READ_LAT cycles after fifo_read
//   fifo_addr_in   FIFO write pointer
//   fifo_addr_out  FIFO read pointer
//   fsm_state      current arbiter state (IDLE/READ/DRAIN), for observation
//
// Handshake: rd_valid is a push-only strobe with no backpressure. A consumer
// must take rd_data in every cycle where its rd_valid bit is high. A request
// is accepted when grant rises and is retired by the matching done pulse.
module fifo_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 6,
    parameter int ADDR_WIDTH = 11,
    parameter int READ_LAT   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [3*NUM_REQ-1:0]    req_len,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      done,
    output logic [7:0]              rd_data,
    output logic [NUM_REQ-1:0]      rd_valid,
    output logic [2:0]              rd_index,
    output logic                    fifo_read,
    input  logic [7:0]              fifo_data,
    input  logic [ADDR_WIDTH-1:0]   fifo_addr_in,
    input  logic [ADDR_WIDTH-1:0]   fifo_addr_out,
    output logic [1:0]              fsm_state
);

    localparam int WW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW = $clog2(READ_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state;
    logic [WW-1:0]         winner;
    logic [WW-1:0]         rr_ptr;
    logic [WW-1:0]         pick;
    logic                  found;
    logic [2:0]            burst_len;
    logic [2:0]            cnt;
    logic [DW-1:0]         dcnt;
    logic [ADDR_WIDTH-1:0] occupancy;
    logic [2:0]            len_c [NUM_REQ];
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    win_onehot;
    logic                  drain_last;
    logic                  pipe_v [READ_LAT];
    logic [2:0]            pipe_i [READ_LAT];

    // Modular subtraction gives the fill level even after a pointer wraps.
    assign occupancy = fifo_addr_in - fifo_addr_out;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            len_c[i] = (req_len[3*i +: 3] > 3'(MAX_BURST)) ? 3'(MAX_BURST)
                                                            : req_len[3*i +: 3];
            eligible[i] = req[i] && (len_c[i] != 3'd0) &&
                          (occupancy >= ADDR_WIDTH'(len_c[i]));
        end
    end

    // The scan starts at rr_ptr. The first eligible index found wins.
    always_comb begin
        logic [WW:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (WW+1)'(k);
            if (idx >= (WW+1)'(NUM_REQ))
                idx = idx - (WW+1)'(NUM_REQ);
            if (!found && eligible[idx[WW-1:0]]) begin
                found = 1'b1;
                pick  = idx[WW-1:0];
            end
        end
    end

    assign drain_last = (dcnt == DW'(READ_LAT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            winner    <= '0;
            rr_ptr    <= '0;
            burst_len <= '0;
            cnt       <= '0;
            dcnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        winner    <= pick;
                        burst_len <= len_c[pick];
                        cnt       <= '0;
                        state     <= S_READ;
                    end
                end
                S_READ: begin
                    if (cnt == burst_len - 3'd1) begin
                        dcnt  <= '0;
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_DRAIN: begin
                    // Grant stays up while the last reads are still in flight.
                    // The done cycle follows, and then the next arbitration.
                    if (drain_last) begin
                        rr_ptr <= (winner == WW'(NUM_REQ-1)) ? '0 : winner + WW'(1);
                        state  <= S_IDLE;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Each entry tracks one outstanding read by its valid bit and byte index.
    // The winner cannot change before the pipe empties, so it is not stored here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_i[i] <= 3'd0;
            end
        end else begin
            pipe_v[0] <= fifo_read;
            pipe_i[0] <= cnt;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_i[i] <= pipe_i[i-1];
            end
        end
    end

    assign win_onehot = NUM_REQ'(1) << winner;
    assign fifo_read  = (state == S_READ);
    assign grant      = ((state == S_READ) || (state == S_DRAIN && !drain_last))
                        ? win_onehot : '0;
    assign done       = (state == S_DRAIN && drain_last) ? win_onehot : '0;
    assign rd_valid   = pipe_v[READ_LAT-1] ? win_onehot : '0;
    assign rd_index   = pipe_v[READ_LAT-1] ? pipe_i[READ_LAT-1] : 3'd0;
    assign rd_data    = fifo_data;
    assign fsm_state  = state;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb_fifo_read_arbiter
//   Bench for fifo_read_arbiter. It contains a small behavioural FIFO read
//   port with 1-cycle latency. Byte content is a fixed function of the read
//   address. A vector table drives single bursts, and hand-written sequences
//   cover round-robin ordering, pointer wrap, occupancy growth and reset in
//   the middle of a burst.
module tb_fifo_read_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int READ_LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [11:0] req_len = '0;
    logic [3:0]  grant, done, rd_valid;
    logic [7:0]  rd_data;
    logic [2:0]  rd_index;
    logic        fifo_read;
    logic [7:0]  fifo_data = '0;
    logic [10:0] fifo_addr_in = '0;
    logic [10:0] fifo_addr_out;
    logic [1:0]  fsm_state;

    logic [10:0] rd_base = '0;
    logic [10:0] rd_count = '0;
    logic [7:0]  exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    fifo_read_arbiter #(
        .NUM_REQ(NUM_REQ), .MAX_BURST(6), .ADDR_WIDTH(11), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len),
        .grant(grant), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_index(rd_index), .fifo_read(fifo_read), .fifo_data(fifo_data),
        .fifo_addr_in(fifo_addr_in), .fifo_addr_out(fifo_addr_out),
        .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- FIFO read-side model ----------------
    function automatic logic [7:0] fifo_byte(input logic [10:0] a);
        return a[7:0] ^ {5'b0, a[10:8]} ^ 8'h3C;
    endfunction

    assign fifo_addr_out = rd_base + rd_count;

    always @(posedge clk) begin
        if (fifo_read) begin
            fifo_data <= fifo_byte(fifo_addr_out);
            rd_count  <= rd_count + 11'd1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("grant_onehot", {31'b0, $onehot0(grant)}, 1);
            check("read_has_grant", {31'b0, (!fifo_read || grant != 4'b0)}, 1);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    function automatic logic [11:0] lens(input int l3, input int l2, input int l1, input int l0);
        return {3'(l3), 3'(l2), 3'(l1), 3'(l0)};
    endfunction

    // Places the read pointer at out_val with occ bytes written ahead of it.
    task automatic set_ptrs(input logic [10:0] out_val, input int occ);
        rd_base      = out_val - rd_count;
        fifo_addr_in = out_val + 11'(occ);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_index"}, rd_index, 0);
        check({tag, "_fifo_read"}, fifo_read, 0);
        check({tag, "_state"}, fsm_state, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset   = 1'b1;
        req     = '0;
        req_len = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic expect_idle(input int n, input string tag);
        bit busy = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (grant != 0 || fifo_read || done != 0) busy = 1;
        end
        check({tag, "_no_grant"}, {31'b0, busy}, 0);
    endtask

    // Waits for a grant and follows the burst to its done pulse. Winner,
    // read count, data order, index, latency and done timing are checked.
    task automatic do_burst(input int exp_win, input int exp_len, input bit drop);
        bit seen = 0, fin = 0, gap = 0;
        int cyc = 0, g_cyc = 0, n_rd = 0, n_val = 0, done_cyc = -1;
        logic [10:0] start;
        logic [7:0]  e;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (grant != 0) seen = 1;
        end
        check("burst_granted", {31'b0, seen}, 1);
        if (!seen) return;
        check("winner", grant, 1 << exp_win);
        start = fifo_addr_out;
        exp_q.delete();
        for (int k = 0; k < exp_len; k++) exp_q.push_back(fifo_byte(start + 11'(k)));
        while (!fin && cyc < 30) begin
            if (grant != 0) g_cyc++;
            if (fifo_read) begin
                if (cyc != n_rd) gap = 1;
                n_rd++;
            end
            if (rd_valid != 0) begin
                check("rd_valid_target", rd_valid, 1 << exp_win);
                check("rd_index", rd_index, n_val);
                check("rd_latency", cyc, n_val + READ_LAT);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rd_data", rd_data, e);
                end else begin
                    check("extra_byte", n_val, exp_len);
                end
                n_val++;
            end
            if (done != 0) begin
                check("done_target", done, 1 << exp_win);
                done_cyc = cyc;
                fin = 1;
                if (drop) req = '0;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", {31'b0, fin}, 1);
        check("grant_cycles", g_cyc, exp_len + READ_LAT);
        check("read_count", n_rd, exp_len);
        check("read_gap", {31'b0, gap}, 0);
        check("valid_count", n_val, exp_len);
        check("done_cycle", done_cyc, exp_len + READ_LAT);
        @(negedge clk);
        check("done_pulse_width", done, 0);
        check("grant_after_done", grant, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  req;
        logic [11:0] lens;
        int          occ;
        int          exp_win;
        int          exp_len;   // 0: no grant expected
    } vec_t;

    vec_t vecs[9];

    initial begin
        // Rows run in order after reset. The round-robin pointer carries from
        // one row to the next, and each comment gives the pointer before the row.
        vecs[0] = '{4'b0001, lens(0,0,0,4), 8,  0, 4};  // rr0 -> 0
        vecs[1] = '{4'b0011, lens(0,0,6,6), 12, 1, 6};  // rr1 -> 1
        vecs[2] = '{4'b0001, lens(0,0,0,7), 10, 0, 6};  // rr2, len 7 clamps to 6
        vecs[3] = '{4'b0010, lens(0,0,4,0), 3,  0, 0};  // rr1, too few bytes
        vecs[4] = '{4'b1000, lens(0,0,0,0), 20, 0, 0};  // rr1, zero length
        vecs[5] = '{4'b1001, lens(0,0,0,2), 5,  0, 2};  // rr1, req3 len0 skipped
        vecs[6] = '{4'b1100, lens(3,1,0,0), 4,  2, 1};  // rr1 -> 2
        vecs[7] = '{4'b1001, lens(3,0,0,3), 6,  3, 3};  // rr3 -> 3
        vecs[8] = '{4'b0110, lens(0,2,5,0), 3,  2, 2};  // rr0, req1 short of data

        apply_reset();

        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            set_ptrs(fifo_addr_out, vecs[v].occ);
            req     = vecs[v].req;
            req_len = vecs[v].lens;
            if (vecs[v].exp_len > 0) do_burst(vecs[v].exp_win, vecs[v].exp_len, 1'b1);
            else expect_idle(8, "vec_idle");
            req = '0;
        end

        // Round-robin with all four held: 0,1,2,3,0.
        apply_reset();
        set_ptrs(fifo_addr_out, 64);
        req     = 4'b1111;
        req_len = lens(6,6,6,6);
        for (int k = 0; k < 5; k++) do_burst(k % 4, 6, k == 4);
        req = '0;

        // Pointer wrap: read pointer 2046, write pointer 2.
        apply_reset();
        set_ptrs(11'd2046, 4);
        check("wrap_setup_in", fifo_addr_in, 2);
        req     = 4'b0001;
        req_len = lens(0,0,0,4);
        do_burst(0, 4, 1'b1);
        check("wrap_ptr_after", fifo_addr_out, 2);

        // Occupancy growth: three bytes wait, the fourth triggers the grant (rr=1).
        @(negedge clk);
        set_ptrs(fifo_addr_out, 3);
        req     = 4'b0010;
        req_len = lens(0,0,4,0);
        expect_idle(6, "grow_wait");
        fifo_addr_in = fifo_addr_in + 11'd1;
        do_burst(1, 4, 1'b1);

        // Reset during a burst. A req0 burst first leaves rr at 1, so a
        // clean reset can be told apart from a stale pointer.
        @(negedge clk);
        set_ptrs(fifo_addr_out, 10);
        req     = 4'b0001;
        req_len = lens(0,0,0,2);
        do_burst(0, 2, 1'b1);

        @(negedge clk);
        set_ptrs(fifo_addr_out, 10);
        req     = 4'b0010;
        req_len = lens(0,0,6,0);
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (grant != 0) seen = 1;
            end
            check("mid_reset_granted", {31'b0, seen}, 1);
        end
        repeat (2) @(negedge clk);
        check("mid_reset_byte2_read", {31'b0, fifo_read}, 1);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        req   = '0;
        reset = 1'b0;
        begin
            bit stray = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (rd_valid != 0 || grant != 0) stray = 1;
            end
            check("post_reset_quiet", {31'b0, stray}, 0);
        end
        @(negedge clk);
        set_ptrs(fifo_addr_out, 8);
        req     = 4'b0011;
        req_len = lens(0,0,2,2);
        do_burst(0, 2, 1'b1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
